// File: rtl/pi_fifo_if.sv
// PI bus bundle for the FIFO window: access strobe, command, address,
// write data from the MCU side and read data back from the bridge.
interface pi_fifo_if;
    logic        pi_act;
    logic        pi_oe;
    logic        pi_we;
    logic        pi_ce_fifo;
    logic [15:0] pi_addr;
    logic [7:0]  pi_dato;
    logic [7:0]  pi_dati;

    modport master (
        output pi_act,
        output pi_oe,
        output pi_we,
        output pi_ce_fifo,
        output pi_addr,
        output pi_dato,
        input  pi_dati
    );

    modport slave (
        input  pi_act,
        input  pi_oe,
        input  pi_we,
        input  pi_ce_fifo,
        input  pi_addr,
        input  pi_dato,
        output pi_dati
    );
endinterface

// File: rtl/pi_fifo.sv
// Dual byte FIFO bridge between the asynchronous PI bus (MCU side) and the
// clk-domain host logic. M2H carries MCU bytes to the host, H2M carries host
// bytes to the MCU; a read-to-clear status byte reports flags and errors.
module pi_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    pi_fifo_if.slave   pi,
    input  logic       h_we,
    input  logic       h_oe,
    input  logic [7:0] h_din,
    output logic [7:0] h_dout,
    output logic       h_rxe,
    output logic       h_txf,
    output logic       irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // PI strobe synchronizer, edge register and access tracking
    logic       act_s1_q, act_s1_d;
    logic       act_s2_q, act_s2_d;
    logic       act_e_q, act_e_d;
    logic [1:0] settle_q, settle_d;
    logic       pi_idle_q, pi_idle_d;
    logic       armed_q, armed_d;

    // Command snapshot taken at rise, used at fall
    logic       sel_ce_q, sel_ce_d;
    logic       sel_st_q, sel_st_d;
    logic       cap_we_q, cap_we_d;
    logic       cap_oe_q, cap_oe_d;
    logic [7:0] cap_d_q, cap_d_d;
    logic [7:0] pi_dati_q, pi_dati_d;

    // FIFO storage and pointers
    logic [7:0]  m2h_mem_q [DEPTH];
    logic [7:0]  m2h_mem_d [DEPTH];
    logic [7:0]  h2m_mem_q [DEPTH];
    logic [7:0]  h2m_mem_d [DEPTH];
    logic [AW:0] m2h_wp_q, m2h_wp_d, m2h_rp_q, m2h_rp_d;
    logic [AW:0] h2m_wp_q, h2m_wp_d, h2m_rp_q, h2m_rp_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;

    // Decoded events
    logic rise, fall, rise_ok, commit;
    logic m2h_empty, m2h_full, h2m_empty, h2m_full;
    logic pi_push_m2h, m2h_pop_ok, m2h_push_ok, m2h_drop;
    logic pi_pop_h2m, h2m_pop_ok, h2m_push_ok, h2m_drop;
    logic udf_set, st_clr;
    logic [7:0] status_byte, h2m_head;

    // Flag decode and event qualification shared by all next-state logic
    always_comb begin
        rise      = act_s2_q & ~act_e_q;
        fall      = ~act_s2_q & act_e_q;
        // A rise seen before the synchronizer has shown pi_act low after
        // reset belongs to an access that reset interrupted; it is ignored.
        rise_ok   = rise & pi_idle_q;
        commit    = fall & armed_q;

        m2h_empty = (m2h_wp_q == m2h_rp_q);
        m2h_full  = (m2h_wp_q[AW] != m2h_rp_q[AW]) &&
                    (m2h_wp_q[AW-1:0] == m2h_rp_q[AW-1:0]);
        h2m_empty = (h2m_wp_q == h2m_rp_q);
        h2m_full  = (h2m_wp_q[AW] != h2m_rp_q[AW]) &&
                    (h2m_wp_q[AW-1:0] == h2m_rp_q[AW-1:0]);

        pi_push_m2h = commit & sel_ce_q & ~sel_st_q & cap_we_q;
        m2h_pop_ok  = h_oe & ~m2h_empty;
        m2h_push_ok = pi_push_m2h & (~m2h_full | m2h_pop_ok);
        m2h_drop    = pi_push_m2h & ~m2h_push_ok;

        pi_pop_h2m  = commit & sel_ce_q & ~sel_st_q & cap_oe_q;
        h2m_pop_ok  = pi_pop_h2m & ~h2m_empty;
        h2m_push_ok = h_we & (~h2m_full | h2m_pop_ok);
        h2m_drop    = h_we & ~h2m_push_ok;

        udf_set = pi_pop_h2m & h2m_empty;
        st_clr  = commit & sel_ce_q & sel_st_q & cap_oe_q;

        h2m_head    = h2m_empty ? 8'hFF : h2m_mem_q[h2m_rp_q[AW-1:0]];
        status_byte = {2'b00, udf_q, ovf_q, m2h_full, m2h_empty,
                       h2m_full, h2m_empty};
    end

    // Synchronizer, settle tracking and rise/fall pairing
    always_comb begin
        act_s1_d  = pi.pi_act;
        act_s2_d  = act_s1_q;
        act_e_d   = act_s2_q;
        settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        pi_idle_d = pi_idle_q | ((settle_q == 2'd2) & ~act_s2_q);
        armed_d   = armed_q;
        if (rise_ok) begin
            armed_d = 1'b1;
        end else if (fall) begin
            armed_d = 1'b0;
        end
    end

    // Command capture and PI read data, both taken at rise
    always_comb begin
        sel_ce_d  = sel_ce_q;
        sel_st_d  = sel_st_q;
        cap_we_d  = cap_we_q;
        cap_oe_d  = cap_oe_q;
        cap_d_d   = cap_d_q;
        pi_dati_d = pi_dati_q;
        if (rise_ok) begin
            sel_ce_d = pi.pi_ce_fifo;
            sel_st_d = pi.pi_addr[15];
            cap_we_d = pi.pi_we;
            cap_oe_d = pi.pi_oe;
            cap_d_d  = pi.pi_dato;
            if (pi.pi_ce_fifo & pi.pi_oe) begin
                pi_dati_d = pi.pi_addr[15] ? status_byte : h2m_head;
            end
        end
    end

    // FIFO pointer/storage updates and sticky error flags
    always_comb begin
        m2h_mem_d = m2h_mem_q;
        h2m_mem_d = h2m_mem_q;
        m2h_wp_d  = m2h_wp_q;
        m2h_rp_d  = m2h_rp_q;
        h2m_wp_d  = h2m_wp_q;
        h2m_rp_d  = h2m_rp_q;
        if (m2h_push_ok) begin
            m2h_mem_d[m2h_wp_q[AW-1:0]] = cap_d_q;
            m2h_wp_d = m2h_wp_q + PTR_ONE;
        end
        if (m2h_pop_ok) begin
            m2h_rp_d = m2h_rp_q + PTR_ONE;
        end
        if (h2m_push_ok) begin
            h2m_mem_d[h2m_wp_q[AW-1:0]] = h_din;
            h2m_wp_d = h2m_wp_q + PTR_ONE;
        end
        if (h2m_pop_ok) begin
            h2m_rp_d = h2m_rp_q + PTR_ONE;
        end
        // A new error in the same cycle as a status read survives the clear
        ovf_d = (ovf_q & ~st_clr) | m2h_drop | h2m_drop;
        udf_d = (udf_q & ~st_clr) | udf_set;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            act_s1_q  <= 1'b0;
            act_s2_q  <= 1'b0;
            act_e_q   <= 1'b0;
            settle_q  <= 2'd0;
            pi_idle_q <= 1'b0;
            armed_q   <= 1'b0;
            sel_ce_q  <= 1'b0;
            sel_st_q  <= 1'b0;
            cap_we_q  <= 1'b0;
            cap_oe_q  <= 1'b0;
            cap_d_q   <= 8'h00;
            pi_dati_q <= 8'hFF;
            m2h_wp_q  <= '0;
            m2h_rp_q  <= '0;
            h2m_wp_q  <= '0;
            h2m_rp_q  <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                m2h_mem_q[i] <= 8'h00;
                h2m_mem_q[i] <= 8'h00;
            end
        end else begin
            act_s1_q  <= act_s1_d;
            act_s2_q  <= act_s2_d;
            act_e_q   <= act_e_d;
            settle_q  <= settle_d;
            pi_idle_q <= pi_idle_d;
            armed_q   <= armed_d;
            sel_ce_q  <= sel_ce_d;
            sel_st_q  <= sel_st_d;
            cap_we_q  <= cap_we_d;
            cap_oe_q  <= cap_oe_d;
            cap_d_q   <= cap_d_d;
            pi_dati_q <= pi_dati_d;
            m2h_wp_q  <= m2h_wp_d;
            m2h_rp_q  <= m2h_rp_d;
            h2m_wp_q  <= h2m_wp_d;
            h2m_rp_q  <= h2m_rp_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            m2h_mem_q <= m2h_mem_d;
            h2m_mem_q <= h2m_mem_d;
        end
    end

    assign pi.pi_dati = pi_dati_q;
    assign h_dout     = m2h_empty ? 8'hFF : m2h_mem_q[m2h_rp_q[AW-1:0]];
    assign h_rxe      = m2h_empty;
    assign h_txf      = h2m_full;
    assign irq        = ~m2h_empty;

endmodule

// File: tb/tb_pi_fifo.sv
// Directed bench for pi_fifo: PI accesses are stretched over several clk
// cycles to mimic a slower SPI-driven bus; host strobes are one clk wide.
module tb_pi_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       h_we = 1'b0;
    logic       h_oe = 1'b0;
    logic [7:0] h_din = 8'h00;
    logic [7:0] h_dout;
    logic       h_rxe, h_txf, irq;
    logic [7:0] rd;
    logic [7:0] exp_b;
    int         check_cnt = 0;
    int         pass_cnt = 0;

    pi_fifo_if pif ();

    pi_fifo #(.DEPTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .pi     (pif.slave),
        .h_we   (h_we),
        .h_oe   (h_oe),
        .h_din  (h_din),
        .h_dout (h_dout),
        .h_rxe  (h_rxe),
        .h_txf  (h_txf),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // One full PI access: act high 5 clk, then low 5 clk; read data sampled
    // just before act drops.
    task automatic pi_access(input logic ce, input logic we, input logic oe,
                             input logic [15:0] addr, input logic [7:0] dato,
                             output logic [7:0] dati);
        @(negedge clk);
        pif.pi_ce_fifo = ce;
        pif.pi_we      = we;
        pif.pi_oe      = oe;
        pif.pi_addr    = addr;
        pif.pi_dato    = dato;
        pif.pi_act     = 1'b1;
        repeat (5) @(negedge clk);
        dati = pif.pi_dati;
        pif.pi_act = 1'b0;
        repeat (5) @(negedge clk);
        pif.pi_we = 1'b0;
        pif.pi_oe = 1'b0;
    endtask

    task automatic host_push(input logic [7:0] d);
        @(negedge clk);
        h_we  = 1'b1;
        h_din = d;
        @(negedge clk);
        h_we  = 1'b0;
    endtask

    task automatic host_pop();
        @(negedge clk);
        h_oe = 1'b1;
        @(negedge clk);
        h_oe = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (pif.pi_dati !== 8'hFF) $display("[TB] FAIL rst_pi_dati: got %h expected ff", pif.pi_dati);
        else pass_cnt++;
        check_cnt++;
        if (h_dout !== 8'hFF) $display("[TB] FAIL rst_h_dout: got %h expected ff", h_dout);
        else pass_cnt++;
        check_cnt++;
        if (h_rxe !== 1'b1) $display("[TB] FAIL rst_h_rxe: got %b expected 1", h_rxe);
        else pass_cnt++;
        check_cnt++;
        if (h_txf !== 1'b0) $display("[TB] FAIL rst_h_txf: got %b expected 0", h_txf);
        else pass_cnt++;
        check_cnt++;
        if (irq !== 1'b0) $display("[TB] FAIL rst_irq: got %b expected 0", irq);
        else pass_cnt++;
        // Reset lands between rise and fall of a PI data write
        pif.pi_ce_fifo = 1'b1;
        pif.pi_we      = 1'b1;
        pif.pi_addr    = 16'h0000;
        pif.pi_dato    = 8'h5A;
        pif.pi_act     = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        pif.pi_act = 1'b0;
        repeat (6) @(negedge clk);
        pif.pi_we = 1'b0;
        check_cnt++;
        if (h_rxe !== 1'b1) $display("[TB] FAIL midrst_h_rxe: got %b expected 1", h_rxe);
        else pass_cnt++;
        check_cnt++;
        if (irq !== 1'b0) $display("[TB] FAIL midrst_irq: got %b expected 0", irq);
        else pass_cnt++;
        check_cnt++;
        if (pif.pi_dati !== 8'hFF) $display("[TB] FAIL midrst_pi_dati: got %h expected ff", pif.pi_dati);
        else pass_cnt++;
    endtask

    task automatic test_m2h();
        pi_access(1'b1, 1'b1, 1'b0, 16'h0000, 8'h11, rd);
        pi_access(1'b1, 1'b1, 1'b0, 16'h0000, 8'h22, rd);
        pi_access(1'b1, 1'b1, 1'b0, 16'h0000, 8'h33, rd);
        check_cnt++;
        if (irq !== 1'b1) $display("[TB] FAIL m2h_irq: got %b expected 1", irq);
        else pass_cnt++;
        check_cnt++;
        if (h_dout !== 8'h11) $display("[TB] FAIL m2h_head0: got %h expected 11", h_dout);
        else pass_cnt++;
        host_pop();
        check_cnt++;
        if (h_dout !== 8'h22) $display("[TB] FAIL m2h_head1: got %h expected 22", h_dout);
        else pass_cnt++;
        host_pop();
        check_cnt++;
        if (h_dout !== 8'h33) $display("[TB] FAIL m2h_head2: got %h expected 33", h_dout);
        else pass_cnt++;
        host_pop();
        check_cnt++;
        if (h_dout !== 8'hFF) $display("[TB] FAIL m2h_head_empty: got %h expected ff", h_dout);
        else pass_cnt++;
        check_cnt++;
        if (h_rxe !== 1'b1) $display("[TB] FAIL m2h_rxe: got %b expected 1", h_rxe);
        else pass_cnt++;
        check_cnt++;
        if (irq !== 1'b0) $display("[TB] FAIL m2h_irq_clear: got %b expected 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_h2m_wrap();
        // One byte parked in M2H keeps its empty/full bits clear in the status
        pi_access(1'b1, 1'b1, 1'b0, 16'h0000, 8'hA5, rd);
        for (int i = 0; i < 16; i++) host_push(8'(i));
        check_cnt++;
        if (h_txf !== 1'b1) $display("[TB] FAIL h2m_txf: got %b expected 1", h_txf);
        else pass_cnt++;
        host_push(8'hEE);
        pi_access(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, rd);
        check_cnt++;
        if (rd !== 8'h12) $display("[TB] FAIL h2m_status_ovf: got %h expected 12", rd);
        else pass_cnt++;
        pi_access(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, rd);
        check_cnt++;
        if (rd !== 8'h02) $display("[TB] FAIL h2m_status_cleared: got %h expected 02", rd);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            pi_access(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, rd);
            exp_b = 8'(i);
            check_cnt++;
            if (rd !== exp_b) $display("[TB] FAIL h2m_read%0d: got %h expected %h", i, rd, exp_b);
            else pass_cnt++;
        end
        pi_access(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, rd);
        check_cnt++;
        if (rd !== 8'hFF) $display("[TB] FAIL h2m_read_empty: got %h expected ff", rd);
        else pass_cnt++;
        pi_access(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, rd);
        check_cnt++;
        if (rd !== 8'h21) $display("[TB] FAIL h2m_status_udf: got %h expected 21", rd);
        else pass_cnt++;
        check_cnt++;
        if (h_dout !== 8'hA5) $display("[TB] FAIL h2m_parked_byte: got %h expected a5", h_dout);
        else pass_cnt++;
        host_pop();
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) pi_access(1'b1, 1'b1, 1'b0, 16'h0000, 8'(8'h40 + i), rd);
        pi_access(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, rd);
        check_cnt++;
        if (rd !== 8'h09) $display("[TB] FAIL full_status: got %h expected 09", rd);
        else pass_cnt++;
        // PI write whose commit cycle coincides with a host pop
        @(negedge clk);
        pif.pi_ce_fifo = 1'b1;
        pif.pi_we      = 1'b1;
        pif.pi_oe      = 1'b0;
        pif.pi_addr    = 16'h0000;
        pif.pi_dato    = 8'h99;
        pif.pi_act     = 1'b1;
        repeat (5) @(negedge clk);
        pif.pi_act = 1'b0;
        repeat (2) @(negedge clk);
        h_oe = 1'b1;
        @(negedge clk);
        h_oe = 1'b0;
        repeat (3) @(negedge clk);
        pif.pi_we = 1'b0;
        check_cnt++;
        if (h_dout !== 8'h41) $display("[TB] FAIL simul_head: got %h expected 41", h_dout);
        else pass_cnt++;
        pi_access(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, rd);
        check_cnt++;
        if (rd !== 8'h09) $display("[TB] FAIL simul_status: got %h expected 09", rd);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(8'h41 + i) : 8'h99;
            check_cnt++;
            if (h_dout !== exp_b) $display("[TB] FAIL simul_drain%0d: got %h expected %h", i, h_dout, exp_b);
            else pass_cnt++;
            host_pop();
        end
        check_cnt++;
        if (h_rxe !== 1'b1) $display("[TB] FAIL simul_drained_rxe: got %b expected 1", h_rxe);
        else pass_cnt++;
    endtask

    task automatic test_window();
        pi_access(1'b0, 1'b1, 1'b0, 16'h0000, 8'h77, rd);
        check_cnt++;
        if (h_rxe !== 1'b1) $display("[TB] FAIL win_nodecode_rxe: got %b expected 1", h_rxe);
        else pass_cnt++;
        pi_access(1'b1, 1'b1, 1'b0, 16'h8000, 8'hFF, rd);
        check_cnt++;
        if (h_rxe !== 1'b1) $display("[TB] FAIL win_statwr_rxe: got %b expected 1", h_rxe);
        else pass_cnt++;
        pi_access(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, rd);
        check_cnt++;
        if (rd !== 8'h05) $display("[TB] FAIL win_status: got %h expected 05", rd);
        else pass_cnt++;
    endtask

    task automatic test_ptr_wrap();
        for (int i = 0; i < 40; i++) begin
            exp_b = 8'(i * 7 + 3);
            pi_access(1'b1, 1'b1, 1'b0, 16'h0000, exp_b, rd);
            check_cnt++;
            if (h_dout !== exp_b) $display("[TB] FAIL wrap_byte%0d: got %h expected %h", i, h_dout, exp_b);
            else pass_cnt++;
            host_pop();
        end
        check_cnt++;
        if (h_rxe !== 1'b1) $display("[TB] FAIL wrap_rxe: got %b expected 1", h_rxe);
        else pass_cnt++;
    endtask

    initial begin
        pif.pi_act     = 1'b0;
        pif.pi_oe      = 1'b0;
        pif.pi_we      = 1'b0;
        pif.pi_ce_fifo = 1'b0;
        pif.pi_addr    = 16'h0000;
        pif.pi_dato    = 8'h00;
        test_reset();
        test_m2h();
        test_h2m_wrap();
        test_simul_full();
        test_window();
        test_ptr_wrap();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/pi_fifo.md
# pi_fifo

Dual byte FIFO bridge behind the PI FIFO window, the 64 KB system-area slot selected by the PI map's `ce_fifo` decode. The MCU reaches it over the SPI-driven PI bus; the host/mapper logic reaches it in the `clk` domain. PI strobes are asynchronous to `clk`, so the block synchronizes `pi_act`, snapshots the command on its rising edge and commits push/pop on its falling edge. It holds an MCU→host FIFO (M2H) and a host→MCU FIFO (H2M), plus a status register.

## Interface
- `DEPTH`, 16: entries per FIFO; power of two, ≥ 4. `AW` = log2(`DEPTH`).
- `clk` in 1: system clock; f_clk ≥ 2 × f_spi_clk.
- `rst` in 1: synchronous, active-high reset.
- `pi_act` in 1: PI access strobe, asynchronous to `clk`.
- `pi_oe` in 1: PI read command.
- `pi_we` in 1: PI write command.
- `pi_ce_fifo` in 1: PI FIFO-window decode.
- `pi_addr` in 16: PI address [15:0]. Bit 15 = 0 selects the data port; bit 15 = 1 selects the status register.
- `pi_dato` in 8: PI write data.
- `pi_dati` out 8: read data returned to the PI.
- `h_we` in 1: host push strobe into H2M, one `clk` per byte.
- `h_oe` in 1: host pop strobe from M2H, one `clk` per byte.
- `h_din` in 8: host write data.
- `h_dout` out 8: M2H head byte; 0xFF when M2H is empty.
- `h_rxe` out 1: M2H empty.
- `h_txf` out 1: H2M full.
- `irq` out 1: asserted while M2H is non-empty.

## Operation
- **PI-side synchronizer**
  - `pi_act` passes through a 2-FF synchronizer, then an edge register.
  - `rise` and `fall` are single-cycle pulses.
- **On `rise`**
  - Capture `sel_ce` = `pi_ce_fifo`, `sel_st` = `pi_addr[15]`, `cap_we` = `pi_we`, `cap_oe` = `pi_oe`, `cap_d` = `pi_dato`.
  - If `sel_ce & cap_oe`: register `pi_dati`. Status selected → status byte. Data selected → H2M head, or 0xFF if H2M is empty.
- **On `fall`, commit with captured values only**
  - Data, `cap_we`: push `cap_d` into M2H. If M2H is full, drop the byte and set `ovf`.
  - Data, `cap_oe`: pop H2M if it is not empty. If it is empty, do nothing and set `udf`.
  - Status, `cap_oe`: clear `ovf` and `udf` (read-to-clear).
  - Status, `cap_we`: ignored.
  - `sel_ce` = 0: no effect.
- **Status byte**
  - [0] H2M empty, [1] H2M full, [2] M2H empty, [3] M2H full, [4] `ovf`, [5] `udf`, [7:6] = 0.
  - Values are sampled at `rise`.
- **Host side**
  - `h_we` pushes `h_din` into H2M. If H2M is full, drop the byte and set `ovf`.
  - `h_oe` pops M2H; ignored when M2H is empty.
  - `h_dout` is a combinational view of the M2H head.
- **FIFOs**
  - Read/write pointers are `AW+1` bits wide and wrap modulo 2·`DEPTH`.
  - Empty = pointers equal. Full = MSBs differ and the low `AW` bits are equal.
  - Storage is a register array.
- **Same-cycle events**
  - Push and pop on one FIFO in the same cycle both occur.
  - When full, a simultaneous pop frees space first, so the push is accepted.
  - When empty, a simultaneous pop is ignored and the push is accepted.
  - A set and a clear of `ovf`/`udf` in the same cycle: set wins.

## Timing
- `rst` (sync): both FIFOs empty, pointers 0, sync/edge registers 0, captures 0, `ovf`/`udf` 0.
- Output reset values: `pi_dati` = 0xFF, `h_dout` = 0xFF, `h_rxe` = 1, `h_txf` = 0, `irq` = 0.
- An access whose `rise` was lost to reset is never committed. A `fall` without a preceding post-reset `rise` commits nothing.
- `pi_dati` is valid ≤ 4 `clk` after the `pi_act` rising edge: 2 synchronizer stages + edge detect + output register. This fits the ≥ 4 spi_clk act window at the minimum clock ratio.
- PI push/pop takes effect 3 `clk` after the `pi_act` falling edge. Host-side flags and `irq` update the following cycle.
- A host push is visible at the H2M head the cycle after `h_we`.
- A host pop updates `h_dout`, `h_rxe` and `irq` the cycle after `h_oe`.
- Back-to-back PI bytes need no idle gap. The next `rise` always follows the previous `fall`'s commit at f_clk ≥ 2 × f_spi.

## Test plan
- **Reset:** assert `rst` mid PI write (between `rise` and `fall`) → no M2H push; `h_rxe` = 1, `irq` = 0, `pi_dati` = 0xFF.
- **MCU→host:** PI writes 0x11, 0x22, 0x33 to the data port → `irq` = 1, `h_dout` = 0x11. Three `h_oe` pulses → `h_dout` steps 0x22, 0x33, then 0xFF; `h_rxe` = 1 after the third.
- **Host→MCU wrap:** host pushes 16 bytes 0x00–0x0F.
  - `h_txf` = 1; the 17th push is dropped.
  - PI status read returns 0x12 (H2M full + `ovf`); a second status read returns 0x02.
  - PI reads 16 data bytes → 0x00–0x0F; the next data read → 0xFF, `udf` set.
- **Simultaneous at full:** M2H full; host `h_oe` in the same cycle as the PI write commit → push accepted, M2H stays full, `ovf` = 0.
- **Window decode:** PI write with `pi_ce_fifo` = 0 → no FIFO change. PI status write 0xFF → status unchanged.
- **Pointer wrap:** 40 alternating push/pop pairs through M2H → byte order preserved across the 2·`DEPTH` pointer wrap.
